// File: rtl/seq_lookahead_subtractor.sv
// Multi-cycle unsigned subtractor: Diff = A - B, Bout = (A < B).
// One CHUNK-bit slice per CALC cycle, LSB slice first. Inside a slice the
// borrow is resolved from per-bit generate/propagate terms. Between slices
// the borrow is carried in a register.
module seq_lookahead_subtractor #(
  parameter int N     = 64,
  parameter int CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         Bout
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  idx;
  logic           brw;
  logic [N-1:0]   a_q, b_q, diff_q;
  logic           bout_q;

  logic             accept, last;
  logic [CHUNK-1:0] a_s, b_s, g, p, d_s;
  logic [CHUNK:0]   br;

  assign accept = in_valid & in_ready;
  assign last   = (idx == IW'(NCH - 1));

  // Current slice of the latched operands
  assign a_s = a_q[idx*CHUNK +: CHUNK];
  assign b_s = b_q[idx*CHUNK +: CHUNK];

  // Borrow generate/propagate and intra-slice borrow chain, seeded by the
  // borrow left over from the previous slice.
  assign br[0] = brw;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign g[i]    = ~a_s[i] & b_s[i];
    assign p[i]    = ~(a_s[i] ^ b_s[i]);
    assign br[i+1] = g[i] | (p[i] & br[i]);
    assign d_s[i]  = a_s[i] ^ b_s[i] ^ br[i];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, per-slice result write and borrow ripple
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      brw    <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      diff_q <= '0;
      bout_q <= 1'b0;
      brw    <= 1'b0;
      idx    <= '0;
    end else if (state == CALC) begin
      diff_q[idx*CHUNK +: CHUNK] <= d_s;
      brw <= br[CHUNK];
      if (last) bout_q <= br[CHUNK];
      else      idx    <= idx + 1'b1;
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_seq_lookahead_subtractor.sv
// Bench for seq_lookahead_subtractor: directed vectors with literal results,
// plus a cycle-level model (A-B arithmetic and a cycles-since-accept counter)
// compared against the DUT on every negedge.
module tb_seq_lookahead_subtractor;

  localparam int N   = 64;
  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, Bout;
  logic [N-1:0] A, B, Diff;

  int n_chk  = 0;
  int n_fail = 0;

  seq_lookahead_subtractor #(.N(N), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase = -1 when idle, otherwise edges since accept; results are
  // available once NCH slice cycles have elapsed.
  int           phase = -1;
  bit           live  = 1'b0;
  logic [N-1:0] m_diff;
  logic         m_bout;

  always @(posedge clk) begin
    if (rst) begin
      phase = -1;
      live  = 1'b1;
    end else if (live) begin
      if (phase < 0) begin
        if (in_valid) begin
          phase = 0;
          {m_bout, m_diff} = {1'b0, A} - {1'b0, B};
        end
      end else if (phase < NCH) begin
        phase++;
      end else if (out_ready) begin
        phase = -1;
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (live && !rst) begin
      chk("model in_ready", {63'd0, in_ready}, {63'd0, phase < 0});
      chk("model out_valid", {63'd0, out_valid}, {63'd0, phase == NCH});
      if (phase == NCH) begin
        chk("model Diff", Diff, m_diff);
        chk("model Bout", {63'd0, Bout}, {63'd0, m_bout});
      end
    end
  end

  // One operation with out_ready held high; checks latency, result, pulse width
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] ed, input logic eb, input string nm);
    int k;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);               // accept edge has passed
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    // visible after NCH further edges, so the consumer samples it on edge NCH+1
    chk({nm, " latency"}, N'(k), N'(NCH));
    chk({nm, " Diff"}, Diff, ed);
    chk({nm, " Bout"}, {63'd0, Bout}, {63'd0, eb});
    @(negedge clk);
    chk({nm, " pulse"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [N-1:0] ra, rb, rd;
    logic         rbo;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset Diff", Diff, 64'd0);
    chk("reset Bout", {63'd0, Bout}, 64'd0);
    rst = 1'b0;

    run_op(64'h0000_0000_0000_0010, 64'h3, 64'h0000_0000_0000_000D, 1'b0, "basic");
    run_op(64'h0001_0000_0000_0000, 64'h1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, "cross");
    run_op(64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "underflow");
    run_op(64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, "equal");

    // Back-pressure with input noise during CALC/DONE
    out_ready = 1'b0;
    @(negedge clk);
    A = 64'hFFFF_0000_1234_5678; B = 64'h0000_FFFF_0000_0001; in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NCH + 10; i++) begin
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; in_valid = 1'($urandom);
      chk("bp in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp out_valid", {63'd0, out_valid}, 64'd1);
    chk("bp Diff", Diff, 64'hFFFE_0001_1234_5677);
    chk("bp Bout", {63'd0, Bout}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp release in_ready", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    A = 64'd5; B = 64'd3; in_valid = 1'b1;
    @(negedge clk);               // edge 0: accept
    in_valid = 1'b0;
    @(negedge clk);               // edge 1
    rst = 1'b1;
    @(negedge clk);               // edge 2: reset
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("midreset no out_valid", {63'd0, seen}, 64'd0);
    chk("midreset in_ready", {63'd0, in_ready}, 64'd1);
    run_op(64'd9, 64'd4, 64'd5, 1'b0, "after reset");

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 8 == 0) ? ra : {$urandom, $urandom};
      {rbo, rd} = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, rd, rbo, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
